ltc_frame_decoder: RTL and testbench

- Consumes the bit stream recovered by the differential Manchester (biphase mark) decoder.
- Searches the bit stream for the 16-bit LTC sync word and assembles 80-bit SMPTE LTC frames.
- Extracts the BCD timecode, the user bits and the drop-frame flag, then publishes them with a one-cycle frame_valid strobe.
- Tracks sync lock and counts sync misses so that downstream display/control logic can qualify the timecode.

---
 rtl/ltc_frame_decoder.sv | 169 ++++++++++++++++
 tb/tb_ltc_frame_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ltc_frame_decoder.sv
// LTC frame decoder: hunts for the 16-bit sync word in the recovered bit stream,
// assembles 80-bit frames and publishes BCD timecode, user bits and lock status.
module ltc_frame_decoder #(
    parameter logic [15:0] SYNC_WORD = 16'hBFFC,
    parameter int unsigned MAX_MISS  = 2,
    parameter bit          CHECK_BCD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        bit_data,
    input  logic        nosignal,
    output logic [5:0]  frames_bcd,
    output logic [6:0]  seconds_bcd,
    output logic [6:0]  minutes_bcd,
    output logic [5:0]  hours_bcd,
    output logic [31:0] user_bits,
    output logic        drop_frame,
    output logic        frame_valid,
    output logic        bcd_err,
    output logic        locked,
    output logic [7:0]  sync_miss_cnt
);

    localparam int unsigned FRAME_W = 80;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned RUN_W   = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         r_state, w_state_nxt;
    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_bit_cnt, w_cnt_nxt;
    logic [RUN_W-1:0]   r_miss_run, w_run_nxt, w_run_inc;
    logic [5:0]         r_frames, r_hours;
    logic [6:0]         r_seconds, r_minutes;
    logic [31:0]        r_user;
    logic               r_df, r_fv, r_bcd_err, r_locked;
    logic [7:0]         r_miss_cnt;

    logic [FRAME_W-1:0] w_sr_next;
    logic               w_accept, w_sync, w_frame, w_miss, w_bcd_bad;
    logic [5:0]         w_frames, w_hours;
    logic [6:0]         w_seconds, w_minutes;
    logic [31:0]        w_user;

    assign w_accept  = bit_valid & ~nosignal;
    assign w_sr_next = {bit_data, r_sr[FRAME_W-1:1]};
    assign w_sync    = (w_sr_next[79:64] == SYNC_WORD);
    assign w_run_inc = r_miss_run + RUN_W'(1);

    // Field extraction from the post-shift frame image
    assign w_frames  = {w_sr_next[9:8],   w_sr_next[3:0]};
    assign w_seconds = {w_sr_next[26:24], w_sr_next[19:16]};
    assign w_minutes = {w_sr_next[42:40], w_sr_next[35:32]};
    assign w_hours   = {w_sr_next[57:56], w_sr_next[51:48]};
    assign w_user    = {w_sr_next[63:60], w_sr_next[55:52], w_sr_next[47:44], w_sr_next[39:36],
                        w_sr_next[31:28], w_sr_next[23:20], w_sr_next[15:12], w_sr_next[7:4]};

    always_comb begin
        w_bcd_bad = 1'b0;
        if (w_frames[3:0] > 4'd9 || w_seconds[3:0] > 4'd9 ||
            w_minutes[3:0] > 4'd9 || w_hours[3:0] > 4'd9)
            w_bcd_bad = 1'b1;
        if (w_frames[5:4] > 2'd2 || w_seconds[6:4] > 3'd5 ||
            w_minutes[6:4] > 3'd5 || w_hours[5:4] > 2'd2)
            w_bcd_bad = 1'b1;
        if (w_hours[5:4] == 2'd2 && w_hours[3:0] > 4'd3)
            w_bcd_bad = 1'b1;
    end

    // Next-state: lock tracking, bit counting and miss accounting
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_run_nxt   = r_miss_run;
        w_frame     = 1'b0;
        w_miss      = 1'b0;
        if (nosignal) begin
            w_state_nxt = ST_HUNT;
            w_cnt_nxt   = '0;
            w_run_nxt   = '0;
        end else if (w_accept) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_sync) begin
                        w_state_nxt = ST_LOCKED;
                        w_cnt_nxt   = '0;
                        w_run_nxt   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_cnt_nxt = '0;
                        if (w_sync) begin
                            w_frame   = 1'b1;
                            w_run_nxt = '0;
                        end else begin
                            w_miss = 1'b1;
                        end
                    end else if (w_sync) begin
                        w_cnt_nxt = '0;
                        w_miss    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
            if (w_miss) begin
                w_run_nxt = w_run_inc;
                if (w_run_inc >= RUN_W'(MAX_MISS))
                    w_state_nxt = ST_HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_miss_run <= '0;
            r_frames   <= '0;
            r_seconds  <= '0;
            r_minutes  <= '0;
            r_hours    <= '0;
            r_user     <= '0;
            r_df       <= 1'b0;
            r_fv       <= 1'b0;
            r_bcd_err  <= 1'b0;
            r_locked   <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_miss_run <= w_run_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_fv       <= w_frame;
            if (w_accept)
                r_sr <= w_sr_next;
            if (w_miss && r_miss_cnt != 8'hFF)
                r_miss_cnt <= r_miss_cnt + 8'd1;
            if (w_frame) begin
                r_frames  <= w_frames;
                r_seconds <= w_seconds;
                r_minutes <= w_minutes;
                r_hours   <= w_hours;
                r_user    <= w_user;
                r_df      <= w_sr_next[10];
                r_bcd_err <= CHECK_BCD & w_bcd_bad;
            end
        end
    end

    assign frames_bcd    = r_frames;
    assign seconds_bcd   = r_seconds;
    assign minutes_bcd   = r_minutes;
    assign hours_bcd     = r_hours;
    assign user_bits     = r_user;
    assign drop_frame    = r_df;
    assign frame_valid   = r_fv;
    assign bcd_err       = r_bcd_err;
    assign locked        = r_locked;
    assign sync_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_ltc_frame_decoder.sv
// Scoreboard bench for ltc_frame_decoder: directed LTC frames, expected frames
// queued at stimulus time and checked by an independent frame_valid monitor.
module tb_ltc_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid, bit_data, nosignal;
    logic [5:0]  frames_bcd, hours_bcd;
    logic [6:0]  seconds_bcd, minutes_bcd;
    logic [31:0] user_bits;
    logic        drop_frame, frame_valid, bcd_err, locked;
    logic [7:0]  sync_miss_cnt;

    ltc_frame_decoder dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
        .nosignal(nosignal), .frames_bcd(frames_bcd), .seconds_bcd(seconds_bcd),
        .minutes_bcd(minutes_bcd), .hours_bcd(hours_bcd), .user_bits(user_bits),
        .drop_frame(drop_frame), .frame_valid(frame_valid), .bcd_err(bcd_err),
        .locked(locked), .sync_miss_cnt(sync_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  fr;
        logic [6:0]  sec;
        logic [6:0]  min;
        logic [5:0]  hr;
        logic [31:0] ub;
        logic        df;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_fv    = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every frame_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            exp_t e;
            n_fv++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("fv_cycle",   32'(cyc),        32'(e.cyc));
                chk("frames",     32'(frames_bcd),  32'(e.fr));
                chk("seconds",    32'(seconds_bcd), 32'(e.sec));
                chk("minutes",    32'(minutes_bcd), 32'(e.min));
                chk("hours",      32'(hours_bcd),   32'(e.hr));
                chk("user_bits",  user_bits,        e.ub);
                chk("drop_frame", 32'(drop_frame),  32'(e.df));
                chk("bcd_err",    32'(bcd_err),     32'(e.err));
            end
        end
    end

    function automatic logic [79:0] build(input logic [5:0] hr, input logic [6:0] mn,
                                          input logic [6:0] sc, input logic [5:0] fr,
                                          input logic [31:0] ub, input logic df,
                                          input logic bad_sync);
        logic [79:0] f;
        logic [15:0] sw;
        f = '0;
        sw = 16'hBFFC;
        f[3:0]   = fr[3:0];  f[9:8]   = fr[5:4];  f[10] = df;
        f[19:16] = sc[3:0];  f[26:24] = sc[6:4];
        f[35:32] = mn[3:0];  f[42:40] = mn[6:4];
        f[51:48] = hr[3:0];  f[57:56] = hr[5:4];
        f[7:4]   = ub[3:0];   f[15:12] = ub[7:4];   f[23:20] = ub[11:8];  f[31:28] = ub[15:12];
        f[39:36] = ub[19:16]; f[47:44] = ub[23:20]; f[55:52] = ub[27:24]; f[63:60] = ub[31:28];
        f[79:64] = sw;
        if (bad_sync) f[78] = ~f[78];
        return f;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_data  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        bit_valid = 1'b0;
        bit_data  = 1'b0;
    endtask

    // Sends a frame; if exp_fv, queues expectation timed to the edge accepting bit 79
    task automatic send_frame(input logic [79:0] f, input bit exp_fv, input exp_t e);
        exp_t ee;
        for (int i = 0; i < 80; i++) begin
            send_bit(f[i]);
            if (i == 79 && exp_fv) begin
                ee = e;
                ee.cyc = cyc + 1;
                exp_q.push_back(ee);
            end
        end
        idle();
    endtask

    logic [79:0] good_f, bad_f, err_f;
    logic [15:0] sync_w;
    exp_t        good_e, err_e;

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; nosignal = 1'b0;
        good_f = build(6'h12, 7'h34, 7'h56, 6'h21, 32'h89ABCDEF, 1'b1, 1'b0);
        bad_f  = build(6'h12, 7'h34, 7'h56, 6'h21, 32'h89ABCDEF, 1'b1, 1'b1);
        err_f  = build(6'h25, 7'h34, 7'h66, 6'h21, 32'h89ABCDEF, 1'b1, 1'b0);
        good_e = '{fr: 6'h21, sec: 7'h56, min: 7'h34, hr: 6'h12, ub: 32'h89ABCDEF,
                   df: 1'b1, err: 1'b0, cyc: 0};
        err_e  = '{fr: 6'h21, sec: 7'h66, min: 7'h34, hr: 6'h25, ub: 32'h89ABCDEF,
                   df: 1'b1, err: 1'b1, cyc: 0};
        sync_w = 16'hBFFC;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_locked",   32'(locked),        32'd0);
        chk("rst_miss_cnt", 32'(sync_miss_cnt), 32'd0);
        chk("rst_hours",    32'(hours_bcd),     32'd0);
        chk("rst_user",     user_bits,          32'd0);
        chk("rst_bcd_err",  32'(bcd_err),       32'd0);

        // First sync locks without a frame, second frame publishes
        send_frame(good_f, 1'b0, good_e);
        chk("lock_first", 32'(locked), 32'd1);
        send_frame(good_f, 1'b1, good_e);

        // Single missed sync tolerated
        send_frame(bad_f, 1'b0, good_e);
        chk("miss1_cnt",    32'(sync_miss_cnt), 32'd1);
        chk("miss1_locked", 32'(locked),        32'd1);
        send_frame(good_f, 1'b1, good_e);

        // Two consecutive misses drop lock, then relock
        send_frame(bad_f, 1'b0, good_e);
        send_frame(bad_f, 1'b0, good_e);
        chk("miss2_locked", 32'(locked),        32'd0);
        chk("miss2_cnt",    32'(sync_miss_cnt), 32'd3);
        send_frame(good_f, 1'b0, good_e);
        chk("relock", 32'(locked), 32'd1);
        send_frame(good_f, 1'b1, good_e);

        // nosignal mid-frame, coincident with a bit strobe
        for (int i = 0; i < 40; i++) send_bit(good_f[i]);
        @(negedge clk);
        bit_valid = 1'b1; bit_data = good_f[40]; nosignal = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        chk("nosig_locked", 32'(locked),      32'd0);
        repeat (8) @(negedge clk);
        nosignal = 1'b0;
        chk("nosig_hours",   32'(hours_bcd),   32'h12);
        chk("nosig_frames",  32'(frames_bcd),  32'h21);
        chk("nosig_seconds", 32'(seconds_bcd), 32'h56);
        send_frame(good_f, 1'b0, good_e);
        chk("nosig_relock", 32'(locked), 32'd1);
        send_frame(good_f, 1'b1, good_e);

        // Out-of-range BCD frame, then a legal frame clears the flag
        send_frame(err_f, 1'b1, err_e);
        repeat (3) @(negedge clk);
        chk("bcd_err_hold", 32'(bcd_err), 32'd1);
        send_frame(good_f, 1'b1, good_e);

        // Sync word appearing 40 bits into a locked frame
        for (int i = 0; i < 24; i++) send_bit(good_f[i]);
        for (int j = 0; j < 16; j++) send_bit(sync_w[j]);
        idle();
        chk("early_cnt",    32'(sync_miss_cnt), 32'd4);
        chk("early_locked", 32'(locked),        32'd1);
        send_frame(good_f, 1'b1, good_e);

        repeat (5) @(negedge clk);
        chk("fv_count",   32'(n_fv),          32'd7);
        chk("queue_left", 32'(exp_q.size()),  32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
